// File: rtl/pointer_pkg.sv
// rtl/pointer_pkg.sv - shared defaults and entry type for the pointer register file
package pointer_pkg;

  localparam int NPTR_DEFAULT   = 64;
  localparam int LBID_W_DEFAULT = 12;
  localparam int OFS_W_DEFAULT  = 16;

  // One pointer entry at default widths (valid bit is kept separately).
  typedef struct packed {
    logic [LBID_W_DEFAULT-1:0] lbid;
    logic [OFS_W_DEFAULT-1:0]  ofs;
  } pointer_t;

endpackage

// File: rtl/pointer_reg_bank.sv
// rtl/pointer_reg_bank.sv - pointer storage with write/add update logic
//
// Ports:
//   clk, rst_n                         clock, async active-low reset (valid bits only)
//   wr_en/wr_addr/wr_lbid/wr_ofs       write port, sets the entry valid
//   add_en/add_addr/add_delta          offset add on a valid entry
//   inv_all                            clear every valid bit
//   rd0_addr, rd1_addr                 combinational raw read addresses
//   rd0_*/rd1_* lbid, ofs, valid       raw (pre-update) entry contents
//   add_hit                            add will be applied this cycle
//   add_miss                           add targets an invalid entry
//   add_sum                            updated offset for the add target
//   add_wrap                           the add crosses the unsigned wrap boundary
module pointer_reg_bank
  import pointer_pkg::*;
#(
  parameter int NPTR   = NPTR_DEFAULT,
  parameter int LBID_W = LBID_W_DEFAULT,
  parameter int OFS_W  = OFS_W_DEFAULT,
  parameter int AW     = $clog2(NPTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [LBID_W-1:0] wr_lbid,
  input  logic [OFS_W-1:0]  wr_ofs,
  input  logic              add_en,
  input  logic [AW-1:0]     add_addr,
  input  logic [OFS_W-1:0]  add_delta,
  input  logic              inv_all,
  input  logic [AW-1:0]     rd0_addr,
  input  logic [AW-1:0]     rd1_addr,
  output logic [LBID_W-1:0] rd0_lbid,
  output logic [OFS_W-1:0]  rd0_ofs,
  output logic              rd0_valid,
  output logic [LBID_W-1:0] rd1_lbid,
  output logic [OFS_W-1:0]  rd1_ofs,
  output logic              rd1_valid,
  output logic              add_hit,
  output logic              add_miss,
  output logic [OFS_W-1:0]  add_sum,
  output logic              add_wrap
);

  // Payload storage is deliberately not reset; it is masked while invalid.
  logic [LBID_W-1:0] lbid_mem [NPTR];
  logic [OFS_W-1:0]  ofs_mem  [NPTR];
  logic [NPTR-1:0]   valid;

  logic             wr_same;
  logic [OFS_W:0]   sum_full;

  always_comb begin
    // A write to the add target wins; the add is silently dropped.
    wr_same  = wr_en && (wr_addr == add_addr);
    sum_full = {1'b0, ofs_mem[add_addr]} + {1'b0, add_delta};
    add_hit  = add_en &&  valid[add_addr] && !wr_same;
    add_miss = add_en && !valid[add_addr] && !wr_same;
    add_sum  = sum_full[OFS_W-1:0];
    // Negative delta added as unsigned: a missing carry means the offset borrowed.
    add_wrap = add_delta[OFS_W-1] ? ~sum_full[OFS_W] : sum_full[OFS_W];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lbid_mem[wr_addr] <= wr_lbid;
      ofs_mem[wr_addr]  <= wr_ofs;
    end
    if (add_hit) begin
      ofs_mem[add_addr] <= add_sum;
    end
  end

  // The write is applied after inv_all so a coincident write survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (inv_all) valid <= '0;
      if (wr_en)   valid[wr_addr] <= 1'b1;
    end
  end

  assign rd0_lbid  = lbid_mem[rd0_addr];
  assign rd0_ofs   = ofs_mem[rd0_addr];
  assign rd0_valid = valid[rd0_addr];
  assign rd1_lbid  = lbid_mem[rd1_addr];
  assign rd1_ofs   = ofs_mem[rd1_addr];
  assign rd1_valid = valid[rd1_addr];

endmodule

// File: rtl/pointer_reg_file.sv
// rtl/pointer_reg_file.sv - dual-read pointer register file with offset add
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   rd0_addr/rd1_addr                  read addresses (1-cycle latency, write-first)
//   rd0_*/rd1_* lbid, ofs, valid       registered read data, zero when invalid
//   wr_en/wr_addr/wr_lbid/wr_ofs       write port
//   add_en/add_addr/add_delta          two's-complement offset add
//   inv_all                            invalidate all entries
//   add_ovf                            pulse: previous add wrapped
//   add_err                            pulse: previous add hit an invalid entry
module pointer_reg_file
  import pointer_pkg::*;
#(
  parameter  int NPTR   = NPTR_DEFAULT,
  parameter  int LBID_W = LBID_W_DEFAULT,
  parameter  int OFS_W  = OFS_W_DEFAULT,
  localparam int AW     = $clog2(NPTR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rd0_addr,
  output logic [LBID_W-1:0] rd0_lbid,
  output logic [OFS_W-1:0]  rd0_ofs,
  output logic              rd0_valid,
  input  logic [AW-1:0]     rd1_addr,
  output logic [LBID_W-1:0] rd1_lbid,
  output logic [OFS_W-1:0]  rd1_ofs,
  output logic              rd1_valid,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [LBID_W-1:0] wr_lbid,
  input  logic [OFS_W-1:0]  wr_ofs,
  input  logic              add_en,
  input  logic [AW-1:0]     add_addr,
  input  logic [OFS_W-1:0]  add_delta,
  input  logic              inv_all,
  output logic              add_ovf,
  output logic              add_err
);

  logic [LBID_W-1:0] raw0_lbid, raw1_lbid;
  logic [OFS_W-1:0]  raw0_ofs,  raw1_ofs;
  logic              raw0_valid, raw1_valid;
  logic              add_hit, add_miss, add_wrap;
  logic [OFS_W-1:0]  add_sum;

  pointer_reg_bank #(
    .NPTR(NPTR), .LBID_W(LBID_W), .OFS_W(OFS_W), .AW(AW)
  ) u_bank (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lbid(wr_lbid), .wr_ofs(wr_ofs),
    .add_en(add_en), .add_addr(add_addr), .add_delta(add_delta),
    .inv_all(inv_all),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_lbid(raw0_lbid), .rd0_ofs(raw0_ofs), .rd0_valid(raw0_valid),
    .rd1_lbid(raw1_lbid), .rd1_ofs(raw1_ofs), .rd1_valid(raw1_valid),
    .add_hit(add_hit), .add_miss(add_miss), .add_sum(add_sum), .add_wrap(add_wrap)
  );

  // Write-first bypass: compute what each addressed entry holds after this edge.
  logic              wr_hit0, wr_hit1;
  logic              nx0_valid, nx1_valid;
  logic [LBID_W-1:0] nx0_lbid, nx1_lbid;
  logic [OFS_W-1:0]  nx0_ofs, nx1_ofs;

  always_comb begin
    wr_hit0   = wr_en && (wr_addr == rd0_addr);
    nx0_valid = wr_hit0 || (raw0_valid && !inv_all);
    nx0_lbid  = '0;
    nx0_ofs   = '0;
    if (nx0_valid) begin
      nx0_lbid = wr_hit0 ? wr_lbid : raw0_lbid;
      nx0_ofs  = wr_hit0 ? wr_ofs
               : (add_hit && (add_addr == rd0_addr)) ? add_sum : raw0_ofs;
    end
  end

  always_comb begin
    wr_hit1   = wr_en && (wr_addr == rd1_addr);
    nx1_valid = wr_hit1 || (raw1_valid && !inv_all);
    nx1_lbid  = '0;
    nx1_ofs   = '0;
    if (nx1_valid) begin
      nx1_lbid = wr_hit1 ? wr_lbid : raw1_lbid;
      nx1_ofs  = wr_hit1 ? wr_ofs
               : (add_hit && (add_addr == rd1_addr)) ? add_sum : raw1_ofs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd0_valid <= 1'b0;
      rd0_lbid  <= '0;
      rd0_ofs   <= '0;
      rd1_valid <= 1'b0;
      rd1_lbid  <= '0;
      rd1_ofs   <= '0;
      add_ovf   <= 1'b0;
      add_err   <= 1'b0;
    end else begin
      rd0_valid <= nx0_valid;
      rd0_lbid  <= nx0_lbid;
      rd0_ofs   <= nx0_ofs;
      rd1_valid <= nx1_valid;
      rd1_lbid  <= nx1_lbid;
      rd1_ofs   <= nx1_ofs;
      add_ovf   <= add_hit && add_wrap;
      add_err   <= add_miss;
    end
  end

endmodule

// File: tb/tb_pointer_reg_file.sv
// tb/tb_pointer_reg_file.sv - directed self-checking bench for pointer_reg_file
module tb_pointer_reg_file;
  import pointer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  rd0_addr, rd1_addr;
  logic [11:0] rd0_lbid, rd1_lbid;
  logic [15:0] rd0_ofs, rd1_ofs;
  logic        rd0_valid, rd1_valid;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [11:0] wr_lbid;
  logic [15:0] wr_ofs;
  logic        add_en;
  logic [5:0]  add_addr;
  logic [15:0] add_delta;
  logic        inv_all;
  logic        add_ovf, add_err;

  int total = 0;
  int bad   = 0;

  pointer_reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .rd0_addr(rd0_addr), .rd0_lbid(rd0_lbid), .rd0_ofs(rd0_ofs), .rd0_valid(rd0_valid),
    .rd1_addr(rd1_addr), .rd1_lbid(rd1_lbid), .rd1_ofs(rd1_ofs), .rd1_valid(rd1_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lbid(wr_lbid), .wr_ofs(wr_ofs),
    .add_en(add_en), .add_addr(add_addr), .add_delta(add_delta),
    .inv_all(inv_all), .add_ovf(add_ovf), .add_err(add_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; add_en = 1'b0; inv_all = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input pointer_t p);
    wr_en = 1'b1; wr_addr = a; wr_lbid = p.lbid; wr_ofs = p.ofs;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; idle();
    wr_addr = '0; wr_lbid = '0; wr_ofs = '0; add_addr = '0; add_delta = '0;
    rd0_addr = 6'd0; rd1_addr = 6'd63;
    #1 rst_n = 1'b0;
    tick(); tick();
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err} !== 31'd0) begin
      bad++; $display("FAIL in_reset_outputs got=%h exp=0", {rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err}); end
    rst_n = 1'b1;
    tick();
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== 29'd0) begin
      bad++; $display("FAIL reset_rd0_addr0 got=%h exp=0", {rd0_valid, rd0_lbid, rd0_ofs}); end
    total++; if ({rd1_valid, rd1_lbid, rd1_ofs} !== 29'd0) begin
      bad++; $display("FAIL reset_rd1_addr63 got=%h exp=0", {rd1_valid, rd1_lbid, rd1_ofs}); end
  endtask

  task automatic test_write_read();
    rd0_addr = 6'd5; rd1_addr = 6'd5;
    do_write(6'd5, '{lbid: 12'h123, ofs: 16'h0010});
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== {1'b1, 12'h123, 16'h0010}) begin
      bad++; $display("FAIL write_first_rd0 got=%h exp=%h", {rd0_valid, rd0_lbid, rd0_ofs}, {1'b1, 12'h123, 16'h0010}); end
    total++; if ({rd1_valid, rd1_lbid, rd1_ofs} !== {1'b1, 12'h123, 16'h0010}) begin
      bad++; $display("FAIL write_first_rd1 got=%h exp=%h", {rd1_valid, rd1_lbid, rd1_ofs}, {1'b1, 12'h123, 16'h0010}); end
  endtask

  task automatic test_add_wrap();
    rd0_addr = 6'd5;
    do_write(6'd5, '{lbid: 12'h123, ofs: 16'hFFF0});
    add_en = 1'b1; add_addr = 6'd5; add_delta = 16'h0020;
    tick(); add_en = 1'b0;
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== {1'b1, 12'h123, 16'h0010}) begin
      bad++; $display("FAIL add_pos_wrap_data got=%h exp=%h", {rd0_valid, rd0_lbid, rd0_ofs}, {1'b1, 12'h123, 16'h0010}); end
    total++; if (add_ovf !== 1'b1) begin bad++; $display("FAIL add_pos_ovf got=%b exp=1", add_ovf); end
    tick();
    total++; if (add_ovf !== 1'b0) begin bad++; $display("FAIL add_pos_ovf_pulse got=%b exp=0", add_ovf); end
    add_en = 1'b1; add_delta = 16'hFFE0;
    tick(); add_en = 1'b0;
    total++; if (rd0_ofs !== 16'hFFF0) begin bad++; $display("FAIL add_neg_wrap_ofs got=%h exp=fff0", rd0_ofs); end
    total++; if (add_ovf !== 1'b1) begin bad++; $display("FAIL add_neg_ovf got=%b exp=1", add_ovf); end
    tick();
    total++; if (add_ovf !== 1'b0) begin bad++; $display("FAIL add_neg_ovf_pulse got=%b exp=0", add_ovf); end
    add_en = 1'b1; add_delta = 16'h0005;
    tick(); add_en = 1'b0;
    total++; if ({rd0_ofs, add_ovf, add_err} !== {16'hFFF5, 2'b00}) begin
      bad++; $display("FAIL add_no_wrap got=%h exp=%h", {rd0_ofs, add_ovf, add_err}, {16'hFFF5, 2'b00}); end
  endtask

  task automatic test_err_conflict();
    rd0_addr = 6'd9;
    add_en = 1'b1; add_addr = 6'd9; add_delta = 16'h0001;
    tick(); add_en = 1'b0;
    total++; if ({add_err, add_ovf} !== 2'b10) begin bad++; $display("FAIL add_invalid_flags got=%b exp=10", {add_err, add_ovf}); end
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== 29'd0) begin
      bad++; $display("FAIL add_invalid_entry got=%h exp=0", {rd0_valid, rd0_lbid, rd0_ofs}); end
    tick();
    total++; if ({add_err, rd0_valid} !== 2'b00) begin bad++; $display("FAIL add_err_pulse got=%b exp=00", {add_err, rd0_valid}); end
    rd0_addr = 6'd7;
    wr_en = 1'b1; wr_addr = 6'd7; wr_lbid = 12'h0AB; wr_ofs = 16'h1234;
    add_en = 1'b1; add_addr = 6'd7; add_delta = 16'h0001;
    tick(); idle();
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err} !== {1'b1, 12'h0AB, 16'h1234, 2'b00}) begin
      bad++; $display("FAIL wr_add_same got=%h exp=%h", {rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err}, {1'b1, 12'h0AB, 16'h1234, 2'b00}); end
    tick();
    total++; if ({rd0_ofs, add_ovf, add_err} !== {16'h1234, 2'b00}) begin
      bad++; $display("FAIL wr_add_same_after got=%h exp=%h", {rd0_ofs, add_ovf, add_err}, {16'h1234, 2'b00}); end
    // Different addresses: write 8 while adding 0x000B to addr 5 (0xFFF5 -> 0x0000, wraps).
    rd0_addr = 6'd8; rd1_addr = 6'd5;
    wr_en = 1'b1; wr_addr = 6'd8; wr_lbid = 12'h888; wr_ofs = 16'h0808;
    add_en = 1'b1; add_addr = 6'd5; add_delta = 16'h000B;
    tick(); idle();
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== {1'b1, 12'h888, 16'h0808}) begin
      bad++; $display("FAIL wr_add_diff_wr got=%h exp=%h", {rd0_valid, rd0_lbid, rd0_ofs}, {1'b1, 12'h888, 16'h0808}); end
    total++; if ({rd1_valid, rd1_lbid, rd1_ofs, add_ovf} !== {1'b1, 12'h123, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL wr_add_diff_add got=%h exp=%h", {rd1_valid, rd1_lbid, rd1_ofs, add_ovf}, {1'b1, 12'h123, 16'h0000, 1'b1}); end
  endtask

  task automatic test_inv_all();
    int nvalid;
    for (int i = 0; i < 64; i++) begin
      do_write(i[5:0], '{lbid: 12'(i), ofs: 16'(i + 'h100)});
    end
    rd0_addr = 6'd63;
    tick();
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== {1'b1, 12'h03F, 16'h013F}) begin
      bad++; $display("FAIL fill_addr63 got=%h exp=%h", {rd0_valid, rd0_lbid, rd0_ofs}, {1'b1, 12'h03F, 16'h013F}); end
    rd0_addr = 6'd3; rd1_addr = 6'd4;
    inv_all = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_lbid = 12'h777; wr_ofs = 16'h4444;
    tick(); idle();
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== {1'b1, 12'h777, 16'h4444}) begin
      bad++; $display("FAIL inv_wr_kept got=%h exp=%h", {rd0_valid, rd0_lbid, rd0_ofs}, {1'b1, 12'h777, 16'h4444}); end
    total++; if ({rd1_valid, rd1_lbid, rd1_ofs} !== 29'd0) begin
      bad++; $display("FAIL inv_other_cleared got=%h exp=0", {rd1_valid, rd1_lbid, rd1_ofs}); end
    nvalid = 0;
    for (int i = 0; i < 64; i++) begin
      rd0_addr = i[5:0];
      tick();
      if (rd0_valid === 1'b1 && i == 3) nvalid++;
      else if (rd0_valid !== 1'b0) nvalid += 100;
    end
    total++; if (nvalid !== 1) begin bad++; $display("FAIL inv_scan got=%0d exp=1", nvalid); end
    // Add with inv_all: judged on the pre-invalidate valid bit, entry still ends invalid.
    rd0_addr = 6'd3;
    inv_all = 1'b1; add_en = 1'b1; add_addr = 6'd3; add_delta = 16'h0001;
    tick(); idle();
    total++; if ({rd0_valid, add_err, add_ovf} !== 3'b000) begin
      bad++; $display("FAIL inv_add got=%b exp=000", {rd0_valid, add_err, add_ovf}); end
  endtask

  task automatic test_async_reset();
    rd0_addr = 6'd5;
    do_write(6'd5, '{lbid: 12'h055, ofs: 16'hFFFF});
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs} !== {1'b1, 12'h055, 16'hFFFF}) begin
      bad++; $display("FAIL pre_reset_read got=%h exp=%h", {rd0_valid, rd0_lbid, rd0_ofs}, {1'b1, 12'h055, 16'hFFFF}); end
    add_en = 1'b1; add_addr = 6'd5; add_delta = 16'h0001;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err} !== 31'd0) begin
      bad++; $display("FAIL async_reset_outputs got=%h exp=0", {rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err}); end
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    total++; if ({rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err} !== 31'd0) begin
      bad++; $display("FAIL after_reset_addr5 got=%h exp=0", {rd0_valid, rd0_lbid, rd0_ofs, add_ovf, add_err}); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_add_wrap();
    test_err_conflict();
    test_inv_all();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
